// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit loads/stores over a 16-bit SRAM as two half-word accesses,
// stalling upstream stages with freeze while the access is in flight.
module mem_stage_sram #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_rm_in,
  input  logic [3:0]         dest_in,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [31:0]        alu_res_out,
  output logic [31:0]        mem_data,
  output logic [3:0]         dest_out,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_dq_oe
);
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     mem_data_q;

  logic            req, is_store, is_load, last, active, hi;
  logic [31:0]     off;
  logic            unused_bits;

  assign req      = mem_r_en_in | mem_w_en_in;
  assign is_store = mem_w_en_in;
  assign is_load  = mem_r_en_in & ~mem_w_en_in;
  assign last     = (cnt_q == CW'(ACCESS_CYCLES - 1));
  assign active   = (state_q == LO) | (state_q == HI);
  assign hi       = (state_q == HI);

  // Byte offset from the SRAM window; bits [1:0] select nothing (word aligned).
  assign off         = alu_res_in - 32'(BASE_ADDR);
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q <= LO;
          cnt_q   <= '0;
        end
        LO: if (last) begin
          state_q <= HI;
          cnt_q   <= '0;
          if (is_load) mem_data_q[15:0] <= sram_rdata;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        HI: if (last) begin
          state_q <= DONE;
          cnt_q   <= '0;
          if (is_load) mem_data_q[31:16] <= sram_rdata;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // DONE is the only unfrozen cycle of a memory op, so the MEM/WB register
  // captures the result exactly once.
  assign freeze       = rst & req & (state_q != DONE);
  assign wb_en_out    = wb_en_in & ~freeze;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;
  assign mem_data     = mem_data_q;

  assign sram_addr  = active ? {off[SRAM_AW:2], hi} : '0;
  assign sram_we_n  = ~(active & is_store);
  assign sram_dq_oe = active & is_store;
  assign sram_wdata = (active & is_store) ? (hi ? val_rm_in[31:16] : val_rm_in[15:0]) : 16'h0;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomized self-checking bench for mem_stage_sram with an SRAM model and a
// word-level reference memory.
module tb_mem_stage_sram;
  localparam int AC = 2;
  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out, freeze;
  logic [31:0] alu_res_out, mem_data;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_dq_oe;

  logic        sram_clr;
  logic [15:0] sram_mem [0:255];
  logic [31:0] ref_mem [0:NW-1];
  logic [31:0] exp_md;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data(mem_data), .dest_out(dest_out), .freeze(freeze),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_dq_oe(sram_dq_oe)
  );

  // Asynchronous-read SRAM with a synchronous write strobe.
  assign sram_rdata = sram_mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= 16'h0;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[7:0]] <= sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input bit wb, input bit rd, input bit wr, input int word,
                       input logic [1:0] lo, input logic [31:0] d, input logic [3:0] dst);
    wb_en_in    = wb;
    mem_r_en_in = rd;
    mem_w_en_in = wr;
    alu_res_in  = 32'(1024 + word * 4) | {30'd0, lo};
    val_rm_in   = d;
    dest_in     = dst;
  endtask

  // Checks every cycle of the op currently on the inputs, then updates the model.
  task automatic check_op(input bit wb, input bit rd, input bit wr, input int word,
                          input logic [31:0] d, input logic [3:0] dst);
    bit is_mem, store, act, half, fz;
    int n;
    is_mem = rd | wr;
    store  = wr;
    n      = is_mem ? 2 + 2 * AC : 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      fz   = is_mem && (k < n - 1);
      act  = is_mem && (k >= 1) && (k <= 2 * AC);
      half = (k > AC);
      chk("freeze", 32'(freeze), 32'(fz));
      chk("wb_en_out", 32'(wb_en_out), 32'(wb && !fz));
      chk("sram_addr", 32'(sram_addr), act ? 32'(word * 2 + int'(half)) : 32'd0);
      chk("sram_we_n", 32'(sram_we_n), 32'(!(act && store)));
      chk("sram_dq_oe", 32'(sram_dq_oe), 32'(act && store));
      chk("sram_wdata", 32'(sram_wdata),
          (act && store) ? (half ? {16'd0, d[31:16]} : {16'd0, d[15:0]}) : 32'd0);
      if (k == 0) begin
        chk("alu_res_out", alu_res_out, alu_res_in);
        chk("dest_out", 32'(dest_out), 32'(dst));
        chk("mem_r_en_out", 32'(mem_r_en_out), 32'(rd));
      end
      if (k == n - 1) begin
        if (rd && !wr) exp_md = ref_mem[word];
        chk("mem_data", mem_data, exp_md);
      end
      @(posedge clk);
      #1;
    end
    if (wr) ref_mem[word] = d;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    exp_md   = 32'h0;
    sram_clr = 1'b1;
    rst      = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 4'h0);

    // Reset held with a load request pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_freeze", 32'(freeze), 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      if (i == 1) chk("rst_mem_data", mem_data, 32'h0);
    end
    @(posedge clk);
    #1;
    sram_clr = 1'b0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 2'b00, 32'h0, 4'h0);
    @(posedge clk);
    #1;

    // Non-memory op passes straight through.
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    alu_res_in = 32'h55; val_rm_in = 32'h0; dest_in = 4'd3;
    @(negedge clk);
    chk("nm_wb_en", 32'(wb_en_out), 32'd1);
    chk("nm_alu", alu_res_out, 32'h55);
    chk("nm_dest", 32'(dest_out), 32'd3);
    chk("nm_freeze", 32'(freeze), 32'd0);
    chk("nm_we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk);
    #1;

    // Store then load at 1032 (SRAM half addresses 4 and 5).
    drive(1'b0, 1'b0, 1'b1, 2, 2'b00, 32'hDEADBEEF, 4'd0);
    check_op(1'b0, 1'b0, 1'b1, 2, 32'hDEADBEEF, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 2, 2'b00, 32'h0, 4'd5);
    check_op(1'b1, 1'b1, 1'b0, 2, 32'h0, 4'd5);
    chk("load_1032", mem_data, 32'hDEADBEEF);

    // Back-to-back loads from words 0 and 1.
    drive(1'b0, 1'b0, 1'b1, 0, 2'b00, 32'h11112222, 4'd0);
    check_op(1'b0, 1'b0, 1'b1, 0, 32'h11112222, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1, 2'b00, 32'h33334444, 4'd0);
    check_op(1'b0, 1'b0, 1'b1, 1, 32'h33334444, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 0, 2'b00, 32'h0, 4'd1);
    check_op(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'd1);
    drive(1'b1, 1'b1, 1'b0, 1, 2'b00, 32'h0, 4'd2);
    check_op(1'b1, 1'b1, 1'b0, 1, 32'h0, 4'd2);
    chk("b2b_second", mem_data, 32'h33334444);

    // Reset during the HI phase of a load; request stays up and the op restarts.
    drive(1'b1, 1'b1, 1'b0, 2, 2'b00, 32'h0, 4'd7);
    repeat (1 + AC) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_freeze", 32'(freeze), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    exp_md = 32'h0;
    @(negedge clk);
    chk("abort_mem_data", mem_data, 32'h0);
    @(posedge clk);
    #1;
    // One IDLE-frozen cycle has already elapsed; the previous op list resumes.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_op(1'b1, 1'b1, 1'b0, 2, 32'h0, 4'd7);
    chk("abort_reload", mem_data, 32'hDEADBEEF);

    // Random mix of non-memory ops, loads, stores and load+store.
    for (int t = 0; t < 60; t++) begin
      bit wb, rd, wr;
      int word;
      logic [31:0] d;
      logic [1:0] lo;
      logic [3:0] dst;
      wb   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 2) == 0);
      word = int'($urandom_range(0, NW - 1));
      d    = $urandom;
      lo   = 2'($urandom_range(0, 3));
      dst  = 4'($urandom_range(0, 15));
      drive(wb, rd, wr, word, lo, d, dst);
      check_op(wb, rd, wr, word, d, dst);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
